prt_lb_arb: RTL and testbench
=============================

PRT_LB_ARB -- requirements
Module: prt_lb_arb

Interface
REQ-001 SHALL have parameter P_ADR_WIDTH, default 22, local bus address width.
REQ-002 SHALL have parameter P_TMO, default 255, read timeout in clock cycles (range 2..65535).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: the ports listed below.
  RST_IN  in  1  asynchronous reset, active-high
  CLK_IN  in  1  system clock
REQ-004 SHALL provide, for each of the two masters (x = 0, 1), the ports below.
  Mx_ADR_IN  in  P_ADR_WIDTH  address
  Mx_DIN_IN  in  32  write data
  Mx_WR_IN  in  1  write request, held until RDY
  Mx_RD_IN  in  1  read request, held until RDY
  Mx_RDY_OUT  out  1  request accepted (1-cycle pulse)
  Mx_DOUT_OUT  out  32  read data
  Mx_VLD_OUT  out  1  read data valid (1-cycle pulse)
REQ-005 SHALL provide the local bus and status ports below.
  LB_ADR_OUT  out  P_ADR_WIDTH  address
  LB_DIN_OUT  out  32  write data
  LB_WR_OUT  out  1  write strobe
  LB_RD_OUT  out  1  read strobe
  LB_DOUT_IN  in  32  read data
  LB_VLD_IN  in  1  read data valid
  STA_TMO_OUT  out  1  read timeout (1-cycle pulse)

Function
REQ-006 SHALL implement states IDLE, WR_END and RD_WAIT.
REQ-007 In IDLE, a master requests when Mx_WR_IN or Mx_RD_IN is high; if both of that master's strobes are high, the write SHALL win and the read stays pending.
REQ-008 Arbitration SHALL be round-robin: with both masters requesting, grant goes to the master not granted last; a single requester is granted immediately.
REQ-009 A grant sampled in cycle N SHALL register LB_ADR/LB_DIN/LB_WR or LB_RD and Mx_RDY_OUT high in cycle N+1 only (1-cycle strobes).
REQ-010 Masters SHALL deassert the request in the cycle after RDY; the arbiter SHALL ignore requests during WR_END and RD_WAIT.
REQ-011 After a write grant, the state SHALL be WR_END for one cycle, then IDLE (peak rate: one write per 2 cycles).
REQ-012 After a read grant, the state SHALL be RD_WAIT; on LB_VLD_IN it SHALL register LB_DOUT_IN to the granted master's Mx_DOUT_OUT with Mx_VLD_OUT high for one cycle, then return to IDLE.
REQ-013 A 16-bit timeout counter SHALL clear on entry to RD_WAIT and increment each RD_WAIT cycle without LB_VLD_IN.
REQ-014 When the count reaches P_TMO, the block SHALL return 32'hDEAD_BEEF with Mx_VLD_OUT, pulse STA_TMO_OUT and go to IDLE.
REQ-015 If LB_VLD_IN and timeout coincide, the block SHALL return the real data and SHALL NOT pulse STA_TMO_OUT.
REQ-016 LB_VLD_IN outside RD_WAIT (late or spurious) SHALL be ignored.
REQ-017 Mx_DOUT_OUT SHALL hold its last value; the non-granted master SHALL never see RDY or VLD.
REQ-018 LB_ADR_OUT and LB_DIN_OUT SHALL hold their last value between strobes.

Reset
REQ-019 Reset SHALL force the state to IDLE, all outputs to 0, the counter to 0 and the last-grant marker to master 1 (so master 0 wins the first contention).
REQ-020 Reset during RD_WAIT SHALL abort the transaction with no VLD or STA_TMO pulse after release.

Structure
REQ-021 Package prt_lb_arb_pkg SHALL hold the state enum, the timeout data constant 32'hDEAD_BEEF and the default P_TMO.
REQ-022 The block SHALL be a single module with no sub-modules.

Verification
REQ-023 Write: M0 write adr 0x10, din 0x1234 -> LB_WR_OUT pulse at N+1 with those values, M0_RDY_OUT pulse, WR_END, then IDLE.
REQ-024 Contention after reset: both masters write simultaneously -> M0 granted first, M1 granted 2 cycles later; then both again -> M0 next, confirming alternation.
REQ-025 Read: M1 read, LB_VLD_IN 5 cycles later with data 0xCAFE0001 -> M1_VLD_OUT with that data 1 cycle later; M0_VLD_OUT stays 0.
REQ-026 Timeout with P_TMO=8: read, no LB_VLD_IN -> after 8 cycles M0_VLD_OUT with 0xDEADBEEF and STA_TMO_OUT pulse; a later LB_VLD_IN is ignored.
REQ-027 Coincidence: LB_VLD_IN in the same cycle the count reaches P_TMO -> real data returned, no STA_TMO_OUT pulse.
REQ-028 Reset asserted mid RD_WAIT -> all outputs 0 and no VLD after release; the next contention grants M0.

Source files
------------

// File: rtl/prt_lb_arb_pkg.sv
// prt_lb_arb shared types and constants.
// Two-master local bus arbiter.
package prt_lb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_END  = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;
  localparam int          DEF_TMO  = 255;

endpackage

// File: rtl/prt_lb_arb_if.sv
// Per-master request/response bundle
// for the local bus arbiter.
interface prt_lb_arb_if #(
  parameter int AW = 22
);
  logic [AW-1:0] adr;
  logic [31:0]   din;
  logic          wr;
  logic          rd;
  logic          rdy;
  logic [31:0]   dout;
  logic          vld;

  modport master (
    output adr, din, wr, rd,
    input  rdy, dout, vld
  );

  modport slave (
    input  adr, din, wr, rd,
    output rdy, dout, vld
  );
endinterface

// File: rtl/prt_lb_arb.sv
// Round-robin arbiter giving two masters
// access to one local bus, with read timeout.
module prt_lb_arb
  import prt_lb_arb_pkg::*;
#(
  parameter int P_ADR_WIDTH = 22,
  parameter int P_TMO       = DEF_TMO
) (
  input  logic                   RST_IN,
  input  logic                   CLK_IN,
  input  logic [P_ADR_WIDTH-1:0] M0_ADR_IN,
  input  logic [31:0]            M0_DIN_IN,
  input  logic                   M0_WR_IN,
  input  logic                   M0_RD_IN,
  output logic                   M0_RDY_OUT,
  output logic [31:0]            M0_DOUT_OUT,
  output logic                   M0_VLD_OUT,
  input  logic [P_ADR_WIDTH-1:0] M1_ADR_IN,
  input  logic [31:0]            M1_DIN_IN,
  input  logic                   M1_WR_IN,
  input  logic                   M1_RD_IN,
  output logic                   M1_RDY_OUT,
  output logic [31:0]            M1_DOUT_OUT,
  output logic                   M1_VLD_OUT,
  output logic [P_ADR_WIDTH-1:0] LB_ADR_OUT,
  output logic [31:0]            LB_DIN_OUT,
  output logic                   LB_WR_OUT,
  output logic                   LB_RD_OUT,
  input  logic [31:0]            LB_DOUT_IN,
  input  logic                   LB_VLD_IN,
  output logic                   STA_TMO_OUT
);

  localparam logic [15:0] TMO_LIM = 16'(P_TMO);

  state_t      state;
  state_t      state_nxt;
  logic        last_gnt;
  logic        cur_m;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        req0;
  logic        req1;
  logic        gnt;
  logic        gnt_m;
  logic        gnt_wr;
  logic        rd_ok;
  logic        rd_tmo;
  logic [31:0] rd_data;

  assign req0    = M0_WR_IN | M0_RD_IN;
  assign req1    = M1_WR_IN | M1_RD_IN;
  assign cnt_inc = cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    gnt_m     = 1'b0;
    gnt_wr    = 1'b0;
    rd_ok     = 1'b0;
    rd_tmo    = 1'b0;
    rd_data   = TMO_DATA;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt    = 1'b1;
          gnt_m  = (req0 & req1) ? ~last_gnt : req1;
          gnt_wr = gnt_m ? M1_WR_IN : M0_WR_IN;
          state_nxt = gnt_wr ? WR_END : RD_WAIT;
        end
      end
      WR_END: state_nxt = IDLE;
      RD_WAIT: begin
        // real data wins over a coincident timeout
        if (LB_VLD_IN) begin
          rd_ok     = 1'b1;
          rd_data   = LB_DOUT_IN;
          state_nxt = IDLE;
        end else if (cnt_inc == TMO_LIM) begin
          rd_tmo    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      last_gnt    <= 1'b1;
      cur_m       <= 1'b0;
      cnt         <= '0;
      LB_ADR_OUT  <= '0;
      LB_DIN_OUT  <= '0;
      LB_WR_OUT   <= 1'b0;
      LB_RD_OUT   <= 1'b0;
      M0_RDY_OUT  <= 1'b0;
      M1_RDY_OUT  <= 1'b0;
      M0_DOUT_OUT <= '0;
      M1_DOUT_OUT <= '0;
      M0_VLD_OUT  <= 1'b0;
      M1_VLD_OUT  <= 1'b0;
      STA_TMO_OUT <= 1'b0;
    end else begin
      LB_WR_OUT   <= 1'b0;
      LB_RD_OUT   <= 1'b0;
      M0_RDY_OUT  <= 1'b0;
      M1_RDY_OUT  <= 1'b0;
      M0_VLD_OUT  <= 1'b0;
      M1_VLD_OUT  <= 1'b0;
      STA_TMO_OUT <= 1'b0;
      if (gnt) begin
        last_gnt   <= gnt_m;
        cur_m      <= gnt_m;
        cnt        <= '0;
        LB_ADR_OUT <= gnt_m ? M1_ADR_IN : M0_ADR_IN;
        LB_WR_OUT  <= gnt_wr;
        LB_RD_OUT  <= ~gnt_wr;
        M0_RDY_OUT <= ~gnt_m;
        M1_RDY_OUT <= gnt_m;
        if (gnt_wr)
          LB_DIN_OUT <= gnt_m ? M1_DIN_IN : M0_DIN_IN;
      end
      if (state == RD_WAIT && !rd_ok && !rd_tmo)
        cnt <= cnt_inc;
      if (rd_ok | rd_tmo) begin
        STA_TMO_OUT <= rd_tmo;
        if (cur_m) begin
          M1_DOUT_OUT <= rd_data;
          M1_VLD_OUT  <= 1'b1;
        end else begin
          M0_DOUT_OUT <= rd_data;
          M0_VLD_OUT  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prt_lb_arb.sv
// Self-checking bench for prt_lb_arb:
// vector table, corner sequences, random vs model.
module tb_prt_lb_arb;
  import prt_lb_arb_pkg::*;

  localparam int AW  = 22;
  localparam int TMO = 8;

  logic CLK_IN = 1'b0;
  logic RST_IN = 1'b1;

  prt_lb_arb_if #(.AW(AW)) m0 ();
  prt_lb_arb_if #(.AW(AW)) m1 ();

  logic [AW-1:0] lb_adr;
  logic [31:0]   lb_din;
  logic          lb_wr;
  logic          lb_rd;
  logic [31:0]   lb_dout;
  logic          lb_vld;
  logic          sta_tmo;

  always #5 CLK_IN = ~CLK_IN;

  prt_lb_arb #(
    .P_ADR_WIDTH(AW),
    .P_TMO      (TMO)
  ) dut (
    .RST_IN     (RST_IN),
    .CLK_IN     (CLK_IN),
    .M0_ADR_IN  (m0.adr),
    .M0_DIN_IN  (m0.din),
    .M0_WR_IN   (m0.wr),
    .M0_RD_IN   (m0.rd),
    .M0_RDY_OUT (m0.rdy),
    .M0_DOUT_OUT(m0.dout),
    .M0_VLD_OUT (m0.vld),
    .M1_ADR_IN  (m1.adr),
    .M1_DIN_IN  (m1.din),
    .M1_WR_IN   (m1.wr),
    .M1_RD_IN   (m1.rd),
    .M1_RDY_OUT (m1.rdy),
    .M1_DOUT_OUT(m1.dout),
    .M1_VLD_OUT (m1.vld),
    .LB_ADR_OUT (lb_adr),
    .LB_DIN_OUT (lb_din),
    .LB_WR_OUT  (lb_wr),
    .LB_RD_OUT  (lb_rd),
    .LB_DOUT_IN (lb_dout),
    .LB_VLD_IN  (lb_vld),
    .STA_TMO_OUT(sta_tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_IN);
    #1;
  endtask

  // {wr, rd, rdy0, rdy1, vld0, vld1, tmo}
  function automatic logic [6:0] ctl();
    return {lb_wr, lb_rd, m0.rdy, m1.rdy,
            m0.vld, m1.vld, sta_tmo};
  endfunction

  task automatic idle_in();
    m0.wr = 1'b0; m0.rd = 1'b0;
    m1.wr = 1'b0; m1.rd = 1'b0;
    m0.adr = '0; m0.din = '0;
    m1.adr = '0; m1.din = '0;
    lb_vld = 1'b0; lb_dout = '0;
  endtask

  task automatic do_reset();
    idle_in();
    RST_IN = 1'b1;
    step();
    step();
    chk("rst_out", 128'({ctl(), lb_adr, lb_din,
                         m0.dout, m1.dout}), 128'(0));
    RST_IN = 1'b0;
  endtask

  typedef struct {
    bit            rs;
    logic [3:0]    req;
    logic [AW-1:0] a0;
    logic [31:0]   d0;
    logic [AW-1:0] a1;
    logic [31:0]   d1;
    logic [6:0]    ec;
    logic [AW-1:0] ea;
    logic [31:0]   ed;
  } vec_t;

  function automatic vec_t mk(
    bit rs, logic [3:0] req,
    logic [AW-1:0] a0, logic [31:0] d0,
    logic [AW-1:0] a1, logic [31:0] d1,
    logic [6:0] ec, logic [AW-1:0] ea,
    logic [31:0] ed);
    vec_t v;
    v.rs = rs; v.req = req;
    v.a0 = a0; v.d0 = d0;
    v.a1 = a1; v.d1 = d1;
    v.ec = ec; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  vec_t tv[16];

  // random-phase master and model state
  bit            pw[2];
  bit            pr[2];
  logic [AW-1:0] pa[2];
  logic [31:0]   pd[2];
  bit            rb;
  bit            rm;
  bit            last;
  bit            w;
  int            rs;
  int            fa;
  logic [6:0]    ec;
  logic [AW-1:0] ea;
  logic [31:0]   ed;
  logic [31:0]   eo[2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // req = {w0, r0, w1, r1}
    tv[0]  = mk(1, 4'b1000, 22'h10, 32'h1234, 22'h0, 32'h0,
                7'b1010000, 22'h10, 32'h1234);
    tv[1]  = mk(0, 4'b0010, 22'h10, 32'h1234, 22'h20, 32'h55,
                7'b0000000, 22'h10, 32'h1234);
    tv[2]  = mk(0, 4'b0010, 22'h10, 32'h1234, 22'h20, 32'h55,
                7'b1001000, 22'h20, 32'h55);
    tv[3]  = mk(0, 4'b0000, 22'h0, 32'h0, 22'h0, 32'h0,
                7'b0000000, 22'h20, 32'h55);
    tv[4]  = mk(1, 4'b1010, 22'h40, 32'hA0, 22'h41, 32'hA1,
                7'b1010000, 22'h40, 32'hA0);
    tv[5]  = mk(0, 4'b0010, 22'h40, 32'hA0, 22'h41, 32'hA1,
                7'b0000000, 22'h40, 32'hA0);
    tv[6]  = mk(0, 4'b0010, 22'h40, 32'hA0, 22'h41, 32'hA1,
                7'b1001000, 22'h41, 32'hA1);
    tv[7]  = mk(0, 4'b1010, 22'h50, 32'hB0, 22'h51, 32'hB1,
                7'b0000000, 22'h41, 32'hA1);
    tv[8]  = mk(0, 4'b1010, 22'h50, 32'hB0, 22'h51, 32'hB1,
                7'b1010000, 22'h50, 32'hB0);
    tv[9]  = mk(0, 4'b0010, 22'h50, 32'hB0, 22'h51, 32'hB1,
                7'b0000000, 22'h50, 32'hB0);
    tv[10] = mk(0, 4'b0010, 22'h50, 32'hB0, 22'h51, 32'hB1,
                7'b1001000, 22'h51, 32'hB1);
    tv[11] = mk(0, 4'b0000, 22'h0, 32'h0, 22'h0, 32'h0,
                7'b0000000, 22'h51, 32'hB1);
    tv[12] = mk(0, 4'b1100, 22'h60, 32'hC0, 22'h0, 32'h0,
                7'b1010000, 22'h60, 32'hC0);
    tv[13] = mk(0, 4'b0100, 22'h60, 32'hC0, 22'h0, 32'h0,
                7'b0000000, 22'h60, 32'hC0);
    tv[14] = mk(0, 4'b0100, 22'h60, 32'hC0, 22'h0, 32'h0,
                7'b0110000, 22'h60, 32'hC0);
    tv[15] = mk(0, 4'b0010, 22'h60, 32'hC0, 22'h70, 32'hD0,
                7'b0000000, 22'h60, 32'hC0);

    idle_in();
    for (int i = 0; i < 16; i++) begin
      if (tv[i].rs) do_reset();
      {m0.wr, m0.rd, m1.wr, m1.rd} = tv[i].req;
      m0.adr = tv[i].a0; m0.din = tv[i].d0;
      m1.adr = tv[i].a1; m1.din = tv[i].d1;
      step();
      chk($sformatf("vec%0d_ctl", i), 128'(ctl()),
          128'(tv[i].ec));
      chk($sformatf("vec%0d_adr", i), 128'(lb_adr),
          128'(tv[i].ea));
      chk($sformatf("vec%0d_din", i), 128'(lb_din),
          128'(tv[i].ed));
    end

    // read on M1, bus answers 5 cycles after strobe
    do_reset();
    m1.rd = 1'b1; m1.adr = 22'h77;
    step();
    chk("rd_strobe", 128'(ctl()), 128'(7'b0101000));
    chk("rd_adr", 128'(lb_adr), 128'(22'h77));
    m1.rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd_wait", 128'(ctl()), 128'(0));
    end
    lb_vld = 1'b1; lb_dout = 32'hCAFE0001;
    step();
    lb_vld = 1'b0;
    chk("rd_vld", 128'(ctl()), 128'(7'b0000010));
    chk("rd_dout", 128'({m0.dout, m1.dout}),
        128'({32'h0, 32'hCAFE0001}));
    step();
    chk("rd_pulse", 128'(ctl()), 128'(0));
    chk("rd_hold", 128'(m1.dout), 128'(32'hCAFE0001));

    // timeout, then late data is ignored
    do_reset();
    m0.rd = 1'b1; m0.adr = 22'h88;
    step();
    chk("to_strobe", 128'(ctl()), 128'(7'b0110000));
    m0.rd = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      step();
      chk("to_wait", 128'(ctl()), 128'(0));
    end
    step();
    chk("to_pulse", 128'(ctl()), 128'(7'b0000101));
    chk("to_data", 128'(m0.dout), 128'(TMO_DATA));
    lb_vld = 1'b1; lb_dout = 32'h1111;
    step();
    lb_vld = 1'b0;
    chk("to_late", 128'(ctl()), 128'(0));
    chk("to_hold", 128'(m0.dout), 128'(TMO_DATA));

    // data arrives in the timeout cycle
    do_reset();
    m0.rd = 1'b1;
    step();
    m0.rd = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    lb_vld = 1'b1; lb_dout = 32'h5A5A1234;
    step();
    lb_vld = 1'b0;
    chk("co_ctl", 128'(ctl()), 128'(7'b0000100));
    chk("co_data", 128'(m0.dout), 128'(32'h5A5A1234));

    // reset in the middle of a read
    do_reset();
    m0.rd = 1'b1; m0.adr = 22'h99;
    step();
    m0.rd = 1'b0;
    step(); step(); step();
    RST_IN = 1'b1;
    #2;
    chk("mr_async", 128'({ctl(), lb_adr, lb_din,
                          m0.dout, m1.dout}), 128'(0));
    step();
    RST_IN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lb_vld = (i == 3);
      lb_dout = 32'h77;
      step();
      chk("mr_quiet", 128'(ctl()), 128'(0));
    end
    lb_vld = 1'b0;
    m0.wr = 1'b1; m0.adr = 22'h1; m0.din = 32'h2;
    m1.wr = 1'b1; m1.adr = 22'h3; m1.din = 32'h4;
    step();
    chk("mr_gnt", 128'(ctl()), 128'(7'b1010000));
    chk("mr_adr", 128'(lb_adr), 128'(22'h1));

    // random traffic against a timing model
    do_reset();
    for (int m = 0; m < 2; m++) begin
      pw[m] = 0; pr[m] = 0; pa[m] = '0; pd[m] = '0;
      eo[m] = '0;
    end
    rb = 0; rm = 0; last = 1; rs = 0; fa = 0;
    ea = '0; ed = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pw[m] && !pr[m] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0: pw[m] = 1;
            1: pr[m] = 1;
            default: begin pw[m] = 1; pr[m] = 1; end
          endcase
          pa[m] = AW'($urandom);
          pd[m] = $urandom;
        end
      end
      m0.wr = pw[0]; m0.rd = pr[0];
      m0.adr = pa[0]; m0.din = pd[0];
      m1.wr = pw[1]; m1.rd = pr[1];
      m1.adr = pa[1]; m1.din = pd[1];
      lb_vld = ($urandom_range(0, 5) == 0);
      lb_dout = $urandom;

      ec = '0;
      if (rb) begin
        if (lb_vld || (t - rs + 1 == TMO)) begin
          eo[rm] = lb_vld ? lb_dout : TMO_DATA;
          ec[2 - int'(rm)] = 1'b1;
          ec[0] = !lb_vld;
          rb = 0;
          fa = t + 1;
        end
      end else if (t >= fa &&
                   (pw[0] || pr[0] || pw[1] || pr[1])) begin
        if ((pw[0] || pr[0]) && (pw[1] || pr[1]))
          w = !last;
        else
          w = pw[1] || pr[1];
        last = w;
        ea = pa[w];
        ec[4 - int'(w)] = 1'b1;
        if (pw[w]) begin
          ec[6] = 1'b1;
          ed = pd[w];
          fa = t + 2;
        end else begin
          ec[5] = 1'b1;
          rb = 1;
          rm = w;
          rs = t + 1;
        end
      end

      step();
      chk("rnd_ctl", 128'(ctl()), 128'(ec));
      chk("rnd_dat",
          128'({lb_adr, lb_din, m0.dout, m1.dout}),
          128'({ea, ed, eo[0], eo[1]}));

      if (m0.rdy) begin
        if (pw[0]) pw[0] = 0; else pr[0] = 0;
      end
      if (m1.rdy) begin
        if (pw[1]) pw[1] = 0; else pr[1] = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
